lsu_mem_port: RTL and testbench

Load/store unit sitting directly upstream of the word-wide data RAM. It accepts one RV32I load/store request at a time from the execute stage over a valid/ready handshake and translates it into RAM word read/write strobes. Sub-word stores are done by read-modify-write, because the RAM has no byte enables. Load results are extracted, sign- or zero-extended, and returned over a valid/ready response channel with an error flag.

---
 rtl/lsu_pkg.sv | 26 ++
 rtl/lsu_mem_port_if.sv | 35 +++
 rtl/lsu_align.sv | 50 +++++
 rtl/lsu_mem_port.sv | 124 ++++++++++++
 tb/tb_lsu_mem_port.sv | 244 ++++++++++++++++++++++++
 5 files changed

// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: RV32I width codes, FSM states
// and the funct3 legality rule for loads and stores.
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD,
    S_CAP,
    S_WR,
    S_RESP
  } state_t;

  // Stores have no unsigned variants; loads additionally allow BU/HU.
  function automatic logic is_legal(input logic we, input logic [2:0] f3);
    if (we) return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
    return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) ||
           (f3 == F3_BU) || (f3 == F3_HU);
  endfunction

endpackage

// File: rtl/lsu_mem_port_if.sv
// Request, response and RAM-side signals of the load/store unit.
// master = execute stage / RAM environment, slave = the LSU itself.
interface lsu_mem_port_if;

  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;

  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_err;

  logic [31:0] mem_address;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] mem_datain;
  logic [31:0] mem_dataout;

  modport master (
    output req_valid, req_we, req_funct3, req_addr, req_wdata, resp_ready, mem_dataout,
    input  req_ready, resp_valid, resp_rdata, resp_err,
           mem_address, mem_read, mem_write, mem_datain
  );

  modport slave (
    input  req_valid, req_we, req_funct3, req_addr, req_wdata, resp_ready, mem_dataout,
    output req_ready, resp_valid, resp_rdata, resp_err,
           mem_address, mem_read, mem_write, mem_datain
  );

endinterface

// File: rtl/lsu_align.sv
// Combinational lane logic: load extract/extend, sub-word store merge into a
// RAM word, and alignment check of an incoming request.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [31:0] word,
  input  logic [31:0] wdata,
  input  logic [1:0]  offset,
  input  logic [2:0]  f3,
  input  logic [1:0]  chk_offset,
  input  logic [2:0]  chk_f3,
  output logic [31:0] rdata,
  output logic [31:0] merged,
  output logic        misaligned
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  assign byte_sel = word[{offset, 3'b000} +: 8];
  assign half_sel = word[{offset[1], 4'b0000} +: 16];

  always_comb begin
    // NOTE: every output gets a default first, so no path leaves a latch.
    rdata  = '0;
    merged = word;
    case (f3)
      F3_B: begin
        rdata = {{24{byte_sel[7]}}, byte_sel};
        merged[{offset, 3'b000} +: 8] = wdata[7:0];
      end
      F3_H: begin
        rdata = {{16{half_sel[15]}}, half_sel};
        merged[{offset[1], 4'b0000} +: 16] = wdata[15:0];
      end
      F3_W: begin
        rdata  = word;
        merged = wdata;
      end
      F3_BU:   rdata = {24'b0, byte_sel};
      F3_HU:   rdata = {16'b0, half_sel};
      default: ;
    endcase
  end

  // Low two funct3 bits give the access size for both signed and unsigned codes.
  assign misaligned = ((chk_f3[1:0] == 2'b01) && chk_offset[0]) ||
                      ((chk_f3[1:0] == 2'b10) && (chk_offset != 2'b00));

endmodule

// File: rtl/lsu_mem_port.sv
// Load/store unit in front of a word-wide RAM without byte enables; sub-word
// stores are read-modify-write. One request in flight at a time.
module lsu_mem_port
  import lsu_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int AW          = 10
) (
  input  logic           clk,
  input  logic           clr,
  lsu_mem_port_if.slave  bus
);

  state_t      state;
  logic        we_q;
  logic [2:0]  f3_q;
  logic [1:0]  off_q;
  logic        resp_valid_q;
  logic        resp_err_q;
  logic [31:0] resp_rdata_q;
  logic        mem_read_q;
  logic        mem_write_q;
  logic [31:0] mem_address_q;
  logic [31:0] mem_datain_q;

  logic [31:0] load_data;
  logic [31:0] merged_word;
  logic        misaligned;
  logic        out_of_range;
  logic        req_err;

  // mem_datain_q doubles as the write buffer: it holds wdata until the merge.
  lsu_align u_align (
    .word       (bus.mem_dataout),
    .wdata      (mem_datain_q),
    .offset     (off_q),
    .f3         (f3_q),
    .chk_offset (bus.req_addr[1:0]),
    .chk_f3     (bus.req_funct3),
    .rdata      (load_data),
    .merged     (merged_word),
    .misaligned (misaligned)
  );

  assign out_of_range = bus.req_addr >= 32'(4 * DEPTH_WORDS);
  assign req_err      = !is_legal(bus.req_we, bus.req_funct3) || misaligned || out_of_range;

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments only.
    if (!clr) begin
      state         <= S_IDLE;
      we_q          <= 1'b0;
      f3_q          <= '0;
      off_q         <= '0;
      resp_valid_q  <= 1'b0;
      resp_err_q    <= 1'b0;
      resp_rdata_q  <= '0;
      mem_read_q    <= 1'b0;
      mem_write_q   <= 1'b0;
      mem_address_q <= '0;
      mem_datain_q  <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.req_valid) begin
            we_q          <= bus.req_we;
            f3_q          <= bus.req_funct3;
            off_q         <= bus.req_addr[1:0];
            mem_datain_q  <= bus.req_wdata;
            mem_address_q <= {{(32 - AW){1'b0}}, bus.req_addr[AW+1:2]};
            resp_rdata_q  <= '0;
            resp_err_q    <= req_err;
            if (req_err) begin
              resp_valid_q <= 1'b1;
              state        <= S_RESP;
            end else if (bus.req_we && (bus.req_funct3 == F3_W)) begin
              mem_write_q <= 1'b1;
              state       <= S_WR;
            end else begin
              mem_read_q <= 1'b1;
              state      <= S_RD;
            end
          end
        end
        S_RD: state <= S_CAP;
        S_CAP: begin
          // Read strobe held through CAP so the RAM keeps dataout valid here.
          mem_read_q <= 1'b0;
          if (we_q) begin
            mem_datain_q <= merged_word;
            mem_write_q  <= 1'b1;
            state        <= S_WR;
          end else begin
            resp_rdata_q <= load_data;
            resp_valid_q <= 1'b1;
            state        <= S_RESP;
          end
        end
        S_WR: begin
          mem_write_q  <= 1'b0;
          resp_valid_q <= 1'b1;
          state        <= S_RESP;
        end
        S_RESP: begin
          if (bus.resp_ready) begin
            resp_valid_q <= 1'b0;
            state        <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.req_ready   = (state == S_IDLE);
  assign bus.resp_valid  = resp_valid_q;
  assign bus.resp_err    = resp_err_q;
  assign bus.resp_rdata  = resp_rdata_q;
  assign bus.mem_read    = mem_read_q;
  assign bus.mem_write   = mem_write_q;
  assign bus.mem_address = mem_address_q;
  assign bus.mem_datain  = mem_datain_q;

endmodule

// File: tb/tb_lsu_mem_port.sv
// Bench for lsu_mem_port: registered-read RAM model, byte-array reference
// model, directed steps from the feature list plus randomized traffic.
`timescale 1ns/1ps
module tb_lsu_mem_port;
  import lsu_pkg::*;

  localparam int DEPTH_WORDS = 1024;
  localparam int AW          = 10;
  localparam int NBYTES      = 4 * DEPTH_WORDS;

  logic clk = 1'b0;
  logic clr;
  always #5 clk = ~clk;

  lsu_mem_port_if bus ();

  lsu_mem_port #(.DEPTH_WORDS(DEPTH_WORDS), .AW(AW)) dut (
    .clk (clk),
    .clr (clr),
    .bus (bus)
  );

  int checks   = 0;
  int failures = 0;

  // RAM seen by the DUT; strobe counters live only in this process.
  logic [31:0] ram [0:DEPTH_WORDS-1];
  logic        ram_ready = 1'b0;
  int          rd_cnt = 0;
  int          wr_cnt = 0;
  int          both_cnt = 0;

  function automatic logic [31:0] init_word(input int i);
    return (32'(i) * 32'h9E37_79B9) ^ 32'h5A5A_0F0F;
  endfunction

  always @(posedge clk) begin
    if (!ram_ready) begin
      for (int i = 0; i < DEPTH_WORDS; i++) ram[i] <= init_word(i);
      ram_ready <= 1'b1;
    end else begin
      if (bus.mem_read)  bus.mem_dataout <= ram[bus.mem_address[AW-1:0]];
      if (bus.mem_write) ram[bus.mem_address[AW-1:0]] <= bus.mem_datain;
    end
    if (bus.mem_read)                  rd_cnt++;
    if (bus.mem_write)                 wr_cnt++;
    if (bus.mem_read && bus.mem_write) both_cnt++;
  end

  // Reference memory as plain bytes, little-endian.
  logic [7:0] ref_bytes [0:NBYTES-1];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ref_word(input logic [31:0] addr);
    logic [31:0] a;
    a = {addr[31:2], 2'b00};
    return {ref_bytes[a+3], ref_bytes[a+2], ref_bytes[a+1], ref_bytes[a]};
  endfunction

  // Outcome of one request from the architectural rules.
  task automatic model_req(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                           input logic [31:0] wdata, output logic err, output logic [31:0] rdata,
                           output int lat, output int n_rd, output int n_wr);
    int size;
    logic legal;
    logic [31:0] v;
    if (we) legal = f3 inside {3'd0, 3'd1, 3'd2};
    else    legal = f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
    size  = 1 << f3[1:0];
    err   = !legal || (addr % size != 0) || (addr >= NBYTES);
    rdata = '0;
    if (err) begin
      lat = 1; n_rd = 0; n_wr = 0;
    end else if (we) begin
      for (int i = 0; i < size; i++) ref_bytes[addr + i] = wdata[8*i +: 8];
      lat  = (size == 4) ? 2 : 4;
      n_rd = (size == 4) ? 0 : 2;
      n_wr = 1;
    end else begin
      v = '0;
      for (int i = 0; i < size; i++) v = v | ({24'b0, ref_bytes[addr + i]} << (8 * i));
      if (!f3[2] && size < 4 && v[8*size-1]) v = v | ~((32'd1 << (8 * size)) - 1);
      rdata = v;
      lat = 3; n_rd = 2; n_wr = 0;
    end
  endtask

  task automatic run_req(input string tag, input logic we, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] wdata, input int hold,
                         output logic [31:0] got_rdata, output logic got_err);
    logic        exp_err;
    logic [31:0] exp_rdata;
    int          exp_lat, exp_rd, exp_wr, lat, rd0, wr0;
    model_req(we, f3, addr, wdata, exp_err, exp_rdata, exp_lat, exp_rd, exp_wr);
    check({tag, " req_ready idle"}, 32'(bus.req_ready), 32'd1);
    rd0 = rd_cnt;
    wr0 = wr_cnt;
    bus.req_valid  = 1'b1;
    bus.req_we     = we;
    bus.req_funct3 = f3;
    bus.req_addr   = addr;
    bus.req_wdata  = wdata;
    bus.resp_ready = 1'b0;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    check({tag, " req_ready busy"}, 32'(bus.req_ready), 32'd0);
    if (!exp_err) check({tag, " mem_address"}, bus.mem_address, {22'b0, addr[11:2]});
    lat = 1;
    while (bus.resp_valid !== 1'b1 && lat < 12) begin
      @(posedge clk); #1;
      lat++;
    end
    check({tag, " latency"}, 32'(lat), 32'(exp_lat));
    check({tag, " resp_err"}, 32'(bus.resp_err), 32'(exp_err));
    check({tag, " resp_rdata"}, bus.resp_rdata, exp_rdata);
    got_rdata = bus.resp_rdata;
    got_err   = bus.resp_err;
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      check({tag, " hold resp_valid"}, 32'(bus.resp_valid), 32'd1);
      check({tag, " hold resp_rdata"}, bus.resp_rdata, got_rdata);
      check({tag, " hold req_ready"}, 32'(bus.req_ready), 32'd0);
    end
    bus.resp_ready = 1'b1;
    @(posedge clk); #1;
    bus.resp_ready = 1'b0;
    check({tag, " resp_valid drop"}, 32'(bus.resp_valid), 32'd0);
    check({tag, " back idle"}, 32'(bus.req_ready), 32'd1);
    check({tag, " read strobes"}, 32'(rd_cnt - rd0), 32'(exp_rd));
    check({tag, " write strobes"}, 32'(wr_cnt - wr0), 32'(exp_wr));
    if (we && !exp_err) check({tag, " ram word"}, ram[addr[11:2]], ref_word(addr));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed=still running expected=finished");
    $fatal(1);
  end

  initial begin
    logic [31:0] rd;
    logic        er;
    logic [31:0] a;
    int          wr0;

    for (int i = 0; i < DEPTH_WORDS; i++)
      for (int b = 0; b < 4; b++) ref_bytes[4*i + b] = init_word(i)[8*b +: 8];

    clr             = 1'b0;
    bus.req_valid   = 1'b0;
    bus.req_we      = 1'b0;
    bus.req_funct3  = '0;
    bus.req_addr    = '0;
    bus.req_wdata   = '0;
    bus.resp_ready  = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset req_ready", 32'(bus.req_ready), 32'd1);
    check("reset resp_valid", 32'(bus.resp_valid), 32'd0);
    check("reset mem_read", 32'(bus.mem_read), 32'd0);
    check("reset mem_write", 32'(bus.mem_write), 32'd0);
    check("reset resp_rdata", bus.resp_rdata, 32'd0);
    clr = 1'b1;

    // Word store then load-back.
    run_req("sw 10", 1'b1, F3_W, 32'h10, 32'hDEAD_BEEF, 0, rd, er);
    run_req("lw 10", 1'b0, F3_W, 32'h10, 32'h0, 0, rd, er);
    check("lw 10 value", rd, 32'hDEAD_BEEF);

    // Byte store/loads.
    run_req("sb 13", 1'b1, F3_B, 32'h13, 32'h0000_0012, 0, rd, er);
    check("sb 13 ram", ram[4], 32'h12AD_BEEF);
    run_req("lb 13", 1'b0, F3_B, 32'h13, 32'h0, 0, rd, er);
    check("lb 13 value", rd, 32'h0000_0012);
    run_req("lbu 11", 1'b0, F3_BU, 32'h11, 32'h0, 0, rd, er);
    check("lbu 11 value", rd, 32'h0000_00BE);
    run_req("lb 11", 1'b0, F3_B, 32'h11, 32'h0, 0, rd, er);
    check("lb 11 value", rd, 32'hFFFF_FFBE);

    // Halfword store/loads; LHU also exercises a held response.
    run_req("sh 12", 1'b1, F3_H, 32'h12, 32'h0000_8001, 0, rd, er);
    check("sh 12 ram", ram[4], 32'h8001_BEEF);
    run_req("lh 12", 1'b0, F3_H, 32'h12, 32'h0, 0, rd, er);
    check("lh 12 value", rd, 32'hFFFF_8001);
    run_req("lhu 12 hold", 1'b0, F3_HU, 32'h12, 32'h0, 5, rd, er);
    check("lhu 12 value", rd, 32'h0000_8001);

    // Error requests.
    run_req("lw 0e", 1'b0, F3_W, 32'h0E, 32'h0, 0, rd, er);
    check("lw 0e err", 32'(er), 32'd1);
    run_req("sh 05", 1'b1, F3_H, 32'h05, 32'h1234, 0, rd, er);
    check("sh 05 err", 32'(er), 32'd1);
    run_req("lw 1000", 1'b0, F3_W, 32'h1000, 32'h0, 0, rd, er);
    check("lw 1000 err", 32'(er), 32'd1);
    run_req("load f3 011", 1'b0, 3'b011, 32'h10, 32'h0, 0, rd, er);
    check("load f3 011 err", 32'(er), 32'd1);

    // Reset while SB 0x20 is in CAP: no write may reach the RAM.
    wr0 = wr_cnt;
    bus.req_valid  = 1'b1;
    bus.req_we     = 1'b1;
    bus.req_funct3 = F3_B;
    bus.req_addr   = 32'h20;
    bus.req_wdata  = 32'h0000_005A;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    @(posedge clk); #1;
    check("cap mem_read", 32'(bus.mem_read), 32'd1);
    clr = 1'b0;
    @(posedge clk); #1;
    clr = 1'b1;
    check("clr req_ready", 32'(bus.req_ready), 32'd1);
    check("clr resp_valid", 32'(bus.resp_valid), 32'd0);
    check("clr resp_err", 32'(bus.resp_err), 32'd0);
    check("clr mem_read", 32'(bus.mem_read), 32'd0);
    check("clr mem_write", 32'(bus.mem_write), 32'd0);
    check("clr resp_rdata", bus.resp_rdata, 32'd0);
    check("clr mem_address", bus.mem_address, 32'd0);
    check("clr mem_datain", bus.mem_datain, 32'd0);
    @(posedge clk); #1;
    check("clr no write", 32'(wr_cnt - wr0), 32'd0);
    check("clr ram word 8", ram[8], ref_word(32'h20));

    // Randomized traffic over a small window plus occasional out-of-range addresses.
    for (int n = 0; n < 200; n++) begin
      if ($urandom_range(0, 9) == 0) a = 32'(NBYTES) + $urandom_range(0, 64);
      else                           a = 32'($urandom_range(0, 31) * 4 + $urandom_range(0, 3));
      run_req("rand", 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), a, $urandom,
              $urandom_range(0, 2), rd, er);
    end

    check("strobe overlap", 32'(both_cnt), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
